// File: rtl/seg_scan_decoder.sv
// Decodes a multiplexed 4-digit 7-segment scan bus back to packed BCD.
// The value is published once STABLE_FRAMES identical error-free frames are seen in a row.
module seg_scan_decoder #(
  parameter int STABLE_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  dig_sel,
  input  logic        seg_stb,
  output logic [15:0] num,
  output logic        num_valid,
  output logic        code_err,
  output logic        sel_err,
  output logic        frame_err
);

  localparam logic [3:0] SF = 4'(STABLE_FRAMES);

  logic        sel_ok;
  logic        s1_vld;
  logic [6:0]  s1_seg;
  logic [3:0]  s1_sel;

  logic [3:0]  seen;
  logic        ferr;
  logic [15:0] fbuf;
  logic [3:0]  cnt;
  logic [15:0] prev;
  logic        prev_ok;

  logic [3:0]  dec_dig;
  logic        dec_bad;
  logic        restart;
  logic [3:0]  seen_nxt;
  logic        ferr_nxt;
  logic [15:0] frame;
  logic        complete;
  logic        same;
  logic [3:0]  cnt_nxt;
  logic        publish;

  assign sel_ok = (dig_sel != 4'd0) && ((dig_sel & (dig_sel - 4'd1)) == 4'd0);

  // Stage 1: capture the strobed sample, rejecting non-one-hot selects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_seg  <= 7'd0;
      s1_sel  <= 4'd0;
      sel_err <= 1'b0;
    end else begin
      s1_vld  <= seg_stb & sel_ok;
      sel_err <= seg_stb & ~sel_ok;
      if (seg_stb && sel_ok) begin
        s1_seg <= seg_in;
        s1_sel <= dig_sel;
      end
    end
  end

  always_comb begin
    dec_bad = 1'b0;
    case (s1_seg)
      7'h7E:   dec_dig = 4'd0;
      7'h30:   dec_dig = 4'd1;
      7'h6D:   dec_dig = 4'd2;
      7'h79:   dec_dig = 4'd3;
      7'h33:   dec_dig = 4'd4;
      7'h5B:   dec_dig = 4'd5;
      7'h5F:   dec_dig = 4'd6;
      7'h70:   dec_dig = 4'd7;
      7'h7F:   dec_dig = 4'd8;
      7'h7B:   dec_dig = 4'd9;
      default: begin
        dec_dig = 4'hF;
        dec_bad = 1'b1;
      end
    endcase
  end

  // A sample landing on an already-filled slot starts a fresh frame with itself.
  always_comb begin
    restart  = |(seen & s1_sel);
    seen_nxt = (restart ? 4'd0 : seen) | s1_sel;
    ferr_nxt = (restart ? 1'b0 : ferr) | dec_bad;
    for (int i = 0; i < 4; i++) begin
      frame[4*i +: 4] = s1_sel[i] ? dec_dig : fbuf[4*i +: 4];
    end
    complete = s1_vld && (seen_nxt == 4'hF);
    same     = prev_ok && (frame == prev);
    cnt_nxt  = 4'd1;
    if (same) begin
      cnt_nxt = (cnt < SF) ? cnt + 4'd1 : cnt;
    end
    publish  = complete && !ferr_nxt && (cnt_nxt == SF) && (!same || (cnt < SF));
  end

  // Stage 2: frame assembly and stability evaluation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen      <= 4'd0;
      ferr      <= 1'b0;
      fbuf      <= 16'd0;
      cnt       <= 4'd0;
      prev      <= 16'd0;
      prev_ok   <= 1'b0;
      num       <= 16'd0;
      num_valid <= 1'b0;
      code_err  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      code_err  <= s1_vld & dec_bad;
      frame_err <= complete & ferr_nxt;
      num_valid <= publish;
      if (s1_vld) begin
        fbuf <= frame;
        if (complete) begin
          seen <= 4'd0;
          ferr <= 1'b0;
        end else begin
          seen <= seen_nxt;
          ferr <= ferr_nxt;
        end
      end
      if (complete) begin
        if (ferr_nxt) begin
          cnt     <= 4'd0;
          prev_ok <= 1'b0;
        end else begin
          cnt     <= cnt_nxt;
          prev    <= frame;
          prev_ok <= 1'b1;
        end
      end
      if (publish) begin
        num <= frame;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed vector table plus randomized scans,
// every cycle compared against a frame-level reference model.
module tb_seg_scan_decoder;

  localparam int SF = 2;
  localparam int NC = 16384;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg_in = 7'd0;
  logic [3:0]  dig_sel = 4'd0;
  logic        seg_stb = 1'b0;
  logic [15:0] num;
  logic        num_valid, code_err, sel_err, frame_err;

  seg_scan_decoder #(.STABLE_FRAMES(SF)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .dig_sel(dig_sel), .seg_stb(seg_stb),
    .num(num), .num_valid(num_valid), .code_err(code_err), .sel_err(sel_err),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [6:0] lut [10];

  // expected pulses indexed by the cycle in which they must be visible
  bit          e_sel [NC];
  bit          e_code [NC];
  bit          e_frm [NC];
  bit          e_nv [NC];
  bit          e_numset [NC];
  logic [15:0] e_numval [NC];
  logic [15:0] m_num = 16'd0;

  int          mdig [4];
  bit          mseen [4];
  bit          mferr;
  logic [15:0] mprev;
  bit          mprev_ok;
  int          mcnt;

  typedef struct {
    logic [6:0]  seg;
    logic [3:0]  sel;
    logic        nv;
    logic [15:0] num;
  } vec_t;
  vec_t vt[$];
  logic [15:0] cur = 16'd0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic int dec(input logic [6:0] s);
    for (int i = 0; i < 10; i++) if (lut[i] == s) return i;
    return -1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      mdig[i] = 0;
      mseen[i] = 0;
    end
    mferr = 0; mprev = 16'd0; mprev_ok = 0; mcnt = 0; m_num = 16'd0;
    for (int i = cyc + 1; i < NC; i++) begin
      e_sel[i] = 0; e_code[i] = 0; e_frm[i] = 0; e_nv[i] = 0; e_numset[i] = 0;
    end
  endtask

  task automatic model_strobe(input logic [6:0] seg, input logic [3:0] sel);
    int k, idx, d, newc;
    bit same, all;
    logic [15:0] frame;
    k = cyc;
    if ($countones(sel) != 1) begin
      e_sel[k+1] = 1;
      return;
    end
    idx = 0;
    for (int i = 0; i < 4; i++) if (sel[i]) idx = i;
    d = dec(seg);
    if (mseen[idx]) begin
      for (int i = 0; i < 4; i++) mseen[i] = 0;
      mferr = 0;
    end
    mdig[idx] = (d < 0) ? 15 : d;
    mseen[idx] = 1;
    if (d < 0) begin
      mferr = 1;
      e_code[k+2] = 1;
    end
    all = mseen[0] && mseen[1] && mseen[2] && mseen[3];
    if (all) begin
      frame = 16'(mdig[0] + 16 * mdig[1] + 256 * mdig[2] + 4096 * mdig[3]);
      for (int i = 0; i < 4; i++) mseen[i] = 0;
      if (mferr) begin
        e_frm[k+2] = 1;
        mcnt = 0;
        mprev_ok = 0;
      end else begin
        same = mprev_ok && (frame == mprev);
        newc = same ? ((mcnt < SF) ? mcnt + 1 : SF) : 1;
        if (newc == SF && (!same || mcnt < SF)) begin
          e_nv[k+2] = 1;
          e_numset[k+2] = 1;
          e_numval[k+2] = frame;
        end
        mcnt = newc;
        mprev = frame;
        mprev_ok = 1;
      end
      mferr = 0;
    end
  endtask

  task automatic mon();
    if (e_numset[cyc]) m_num = e_numval[cyc];
    chk("sel_err", 16'(sel_err), 16'(e_sel[cyc]));
    chk("code_err", 16'(code_err), 16'(e_code[cyc]));
    chk("frame_err", 16'(frame_err), 16'(e_frm[cyc]));
    chk("num_valid", 16'(num_valid), 16'(e_nv[cyc]));
    chk("num", num, m_num);
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    mon();
  endtask

  task automatic drive(input bit stb, input logic [6:0] seg, input logic [3:0] sel);
    @(negedge clk);
    seg_stb = stb;
    seg_in  = seg;
    dig_sel = sel;
    if (stb) model_strobe(seg, sel);
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 7'd0, 4'd0);
  endtask

  task automatic add(input logic [6:0] seg, input logic [3:0] sel);
    vt.push_back('{seg, sel, 1'b0, cur});
  endtask

  task automatic pub(input logic [6:0] seg, input logic [3:0] sel, input logic [15:0] v);
    cur = v;
    vt.push_back('{seg, sel, 1'b1, cur});
  endtask

  task automatic add_frame(input int d3, input int d2, input int d1, input int d0);
    add(lut[d0], 4'b0001); add(lut[d1], 4'b0010); add(lut[d2], 4'b0100); add(lut[d3], 4'b1000);
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    rst_n = 1'b0;
    seg_stb = 1'b0;
    model_clear();
    #1;
    chk("num_in_reset", num, 16'd0);
    chk("num_valid_in_reset", 16'(num_valid), 16'd0);
    for (int i = 0; i < hold; i++) tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    lut = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

    // directed vectors: alternating 1234/1235, then 3210 x3, error frame, 5678,
    // select error mid-frame, restart after a bad sample
    add_frame(1, 2, 3, 4); add_frame(1, 2, 3, 5); add_frame(1, 2, 3, 4);
    add_frame(3, 2, 1, 0);
    add(lut[0], 4'b0001); add(lut[1], 4'b0010); add(lut[2], 4'b0100); pub(lut[3], 4'b1000, 16'h3210);
    add_frame(3, 2, 1, 0);
    add(lut[8], 4'b0001); add(lut[7], 4'b0010); add(7'h00, 4'b0100); add(lut[5], 4'b1000);
    add_frame(5, 6, 7, 8);
    add(lut[8], 4'b0001); add(lut[7], 4'b0010); add(lut[6], 4'b0100); pub(lut[5], 4'b1000, 16'h5678);
    add(lut[1], 4'b0001); add(lut[2], 4'b0010); add(lut[3], 4'b0011);
    add(lut[3], 4'b0100); add(lut[4], 4'b1000);
    add(lut[1], 4'b0001); add(lut[2], 4'b0010); add(lut[3], 4'b0100); pub(lut[4], 4'b1000, 16'h4321);
    add(lut[9], 4'b0001); add(7'h00, 4'b0010); add(lut[9], 4'b0001);
    add(lut[9], 4'b0010); add(lut[9], 4'b0100); add(lut[9], 4'b1000);
    add(lut[9], 4'b0001); add(lut[9], 4'b0010); add(lut[9], 4'b0100); pub(lut[9], 4'b1000, 16'h9999);

    model_clear();
    for (int i = 0; i < 3; i++) tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    idle(2);

    foreach (vt[i]) begin
      drive(1, vt[i].seg, vt[i].sel);
      drive(0, 7'd0, 4'd0);
      chk("vec_num_valid", 16'(num_valid), 16'(vt[i].nv));
      chk("vec_num", num, vt[i].num);
    end
    idle(2);

    // reset mid-frame while 9999 is published
    drive(1, lut[1], 4'b0001);
    drive(1, lut[2], 4'b0010);
    do_reset(2);
    for (int r = 0; r < 2; r++) begin
      drive(1, lut[1], 4'b0001); drive(1, lut[2], 4'b0010);
      drive(1, lut[3], 4'b0100); drive(1, lut[4], 4'b1000);
    end
    drive(0, 7'd0, 4'd0);
    chk("post_reset_pub", 16'(num_valid), 16'd1);
    drive(0, 7'd0, 4'd0);
    chk("post_reset_num", num, 16'h4321);

    // back-to-back frames with no gaps, next frame starting right after completion
    for (int r = 0; r < 3; r++) begin
      drive(1, lut[8], 4'b1000); drive(1, lut[0], 4'b0001);
      drive(1, lut[6], 4'b0100); drive(1, lut[2], 4'b0010);
    end
    drive(1, lut[5], 4'b0100);
    idle(3);
    chk("burst_num", num, 16'h8620);

    // randomized scans
    for (int f = 0; f < 60; f++) begin
      int d [4];
      int ord [4];
      int reps, x, t, j2;
      logic [6:0] c;
      logic [3:0] bs;
      for (int i = 0; i < 4; i++) begin
        d[i] = $urandom_range(0, 9);
        ord[i] = i;
      end
      reps = $urandom_range(1, 3);
      for (int r = 0; r < reps; r++) begin
        for (int i = 3; i > 0; i--) begin
          j2 = $urandom_range(0, i);
          t = ord[i]; ord[i] = ord[j2]; ord[j2] = t;
        end
        for (int j = 0; j < 4; j++) begin
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
          x = $urandom_range(0, 24);
          c = lut[d[ord[j]]];
          if (x == 0) begin
            bs = 4'($urandom);
            if ($countones(bs) == 1) bs = 4'b0000;
            drive(1, lut[$urandom_range(0, 9)], bs);
          end else if (x == 1) begin
            c = 7'($urandom);
            if (dec(c) >= 0) c = 7'h00;
          end else if (x == 2 && j > 0) begin
            drive(1, lut[d[ord[0]]], 4'(1 << ord[0]));
          end
          drive(1, c, 4'(1 << ord[j]));
        end
      end
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
